// File: rtl/dvp_frame_scheduler_pkg.sv
// Shared types and widths for the DVP frame scheduler.
package dvp_frame_scheduler_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned SKIP_W  = 4;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitSof = 2'd1,
    StCapture = 2'd2,
    StSkip    = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dvp_timing_tracker.sv
// Registers DVP syncs, derives edges and the coordinates of the pixel currently on the bus.
module dvp_timing_tracker
  import dvp_frame_scheduler_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_vs,
  input  logic               i_hs,
  output logic               o_vs_rise,
  output logic               o_vs_fall,
  output logic               o_hs_fall,
  output logic               o_pix_valid,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y
);

  logic               vs_q, hs_q;
  logic [COORD_W-1:0] x_q, y_q, y_d;

  assign o_vs_rise   = i_vs & ~vs_q;
  assign o_vs_fall   = ~i_vs & vs_q;
  assign o_hs_fall   = ~i_hs & hs_q;
  assign o_pix_valid = i_vs & i_hs;

  // x_q counts valid cycles already seen in the current run, so it is the current column.
  assign o_x = o_pix_valid ? x_q : '0;
  assign o_y = o_vs_rise ? '0 : y_q;

  always_comb begin
    y_d = y_q;
    if (o_vs_rise) begin
      y_d = '0;
    end else if (o_hs_fall) begin
      y_d = y_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_q <= 1'b0;
      hs_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      vs_q <= i_vs;
      hs_q <= i_hs;
      x_q  <= o_pix_valid ? x_q + 1'b1 : '0;
      y_q  <= y_d;
    end
  end

endmodule

// File: rtl/dvp_frame_scheduler.sv
// Schedules whole-frame DVP captures with frame skipping and emits a registered ROI pixel stream.
module dvp_frame_scheduler
  import dvp_frame_scheduler_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_dvp_vs,
  input  logic               i_dvp_hs,
  input  logic [PIX_W-1:0]   i_dvp_data,
  input  logic               i_arm,
  input  logic               i_ds_ready,
  input  logic [COORD_W-1:0] i_cfg_x0,
  input  logic [COORD_W-1:0] i_cfg_y0,
  input  logic [COORD_W-1:0] i_cfg_w,
  input  logic [COORD_W-1:0] i_cfg_h,
  input  logic [SKIP_W-1:0]  i_cfg_skip,
  output logic               o_roi_valid,
  output logic               o_roi_sof,
  output logic               o_roi_eol,
  output logic [PIX_W-1:0]   o_roi_data,
  output logic [COORD_W-1:0] o_roi_x,
  output logic [COORD_W-1:0] o_roi_y,
  output logic               o_frame_done,
  output logic               o_busy,
  output logic [1:0]         o_state,
  output logic [CNT_W-1:0]   o_cnt_captured,
  output logic [CNT_W-1:0]   o_cnt_dropped
);

  logic               vs_rise, vs_fall, hs_fall, pix_valid;
  logic [COORD_W-1:0] x, y;

  dvp_timing_tracker u_timing (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_vs       (i_dvp_vs),
    .i_hs       (i_dvp_hs),
    .o_vs_rise  (vs_rise),
    .o_vs_fall  (vs_fall),
    .o_hs_fall  (hs_fall),
    .o_pix_valid(pix_valid),
    .o_x        (x),
    .o_y        (y)
  );

  state_e             state_q, state_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  logic [COORD_W-1:0] cfg_x0_q, cfg_y0_q, cfg_w_q, cfg_h_q;
  logic [SKIP_W-1:0]  cfg_skip_q;
  logic               cfg_latch, cap_inc, drop_inc, done_d;
  logic [CNT_W-1:0]   cnt_cap_q, cnt_drop_q;

  logic               roi_valid_q, roi_sof_q, roi_eol_q, frame_done_q;
  logic [PIX_W-1:0]   roi_data_q;
  logic [COORD_W-1:0] roi_x_q, roi_y_q;

  // ROI bounds in 17 bits so x0+w near the top of the range cannot wrap into a false hit.
  logic [COORD_W:0] x_ext, y_ext, x_end, y_end;
  logic             hit, hit_sof, hit_eol;

  always_comb begin
    x_ext   = {1'b0, x};
    y_ext   = {1'b0, y};
    x_end   = {1'b0, cfg_x0_q} + {1'b0, cfg_w_q};
    y_end   = {1'b0, cfg_y0_q} + {1'b0, cfg_h_q};
    hit     = (state_q == StCapture) && pix_valid &&
              (x_ext >= {1'b0, cfg_x0_q}) && (x_ext < x_end) &&
              (y_ext >= {1'b0, cfg_y0_q}) && (y_ext < y_end);
    hit_sof = hit && (x == cfg_x0_q) && (y == cfg_y0_q);
    hit_eol = hit && (x_ext == x_end - 1'b1);
  end

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    cfg_latch = 1'b0;
    cap_inc   = 1'b0;
    drop_inc  = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      // A vs_rise coinciding with arm here is ignored: a partial frame is never captured.
      StIdle: begin
        if (i_arm) begin
          state_d = StWaitSof;
          skip_d  = '0;
        end
      end
      StWaitSof: begin
        if (!i_arm) begin
          state_d = StIdle;
        end else if (vs_rise) begin
          if (skip_q != '0) begin
            state_d = StSkip;
            skip_d  = skip_q - 1'b1;
          end else if (i_ds_ready) begin
            state_d   = StCapture;
            cfg_latch = 1'b1;
          end else begin
            state_d  = StSkip;
            drop_inc = 1'b1;
          end
        end
      end
      StCapture: begin
        if (vs_fall) begin
          done_d  = 1'b1;
          cap_inc = 1'b1;
          skip_d  = cfg_skip_q;
          state_d = i_arm ? StWaitSof : StIdle;
        end
      end
      StSkip: begin
        if (vs_fall) begin
          state_d = i_arm ? StWaitSof : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      skip_q       <= '0;
      cfg_x0_q     <= '0;
      cfg_y0_q     <= '0;
      cfg_w_q      <= '0;
      cfg_h_q      <= '0;
      cfg_skip_q   <= '0;
      cnt_cap_q    <= '0;
      cnt_drop_q   <= '0;
      roi_valid_q  <= 1'b0;
      roi_sof_q    <= 1'b0;
      roi_eol_q    <= 1'b0;
      roi_data_q   <= '0;
      roi_x_q      <= '0;
      roi_y_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      frame_done_q <= done_d;
      roi_valid_q  <= hit;
      roi_sof_q    <= hit_sof;
      roi_eol_q    <= hit_eol;
      if (cfg_latch) begin
        cfg_x0_q   <= i_cfg_x0;
        cfg_y0_q   <= i_cfg_y0;
        cfg_w_q    <= i_cfg_w;
        cfg_h_q    <= i_cfg_h;
        cfg_skip_q <= i_cfg_skip;
      end
      if (cap_inc) begin
        cnt_cap_q <= sat_inc(cnt_cap_q);
      end
      if (drop_inc) begin
        cnt_drop_q <= sat_inc(cnt_drop_q);
      end
      if (hit) begin
        roi_data_q <= i_dvp_data;
        roi_x_q    <= x;
        roi_y_q    <= y;
      end
    end
  end

  assign o_roi_valid    = roi_valid_q;
  assign o_roi_sof      = roi_sof_q;
  assign o_roi_eol      = roi_eol_q;
  assign o_roi_data     = roi_data_q;
  assign o_roi_x        = roi_x_q;
  assign o_roi_y        = roi_y_q;
  assign o_frame_done   = frame_done_q;
  assign o_busy         = (state_q == StCapture);
  assign o_state        = state_q;
  assign o_cnt_captured = cnt_cap_q;
  assign o_cnt_dropped  = cnt_drop_q;

endmodule

// File: tb/tb_dvp_frame_scheduler.sv
// Directed + randomized frames against a frame-level reference model of the scheduler.
module tb_dvp_frame_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst, i_dvp_vs, i_dvp_hs, i_arm, i_ds_ready;
  logic [7:0]  i_dvp_data;
  logic [15:0] i_cfg_x0, i_cfg_y0, i_cfg_w, i_cfg_h;
  logic [3:0]  i_cfg_skip;
  logic        o_roi_valid, o_roi_sof, o_roi_eol, o_frame_done, o_busy;
  logic [7:0]  o_roi_data;
  logic [15:0] o_roi_x, o_roi_y, o_cnt_captured, o_cnt_dropped;
  logic [1:0]  o_state;

  always #5 i_clk = ~i_clk;

  dvp_frame_scheduler dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dvp_vs(i_dvp_vs), .i_dvp_hs(i_dvp_hs),
    .i_dvp_data(i_dvp_data), .i_arm(i_arm), .i_ds_ready(i_ds_ready),
    .i_cfg_x0(i_cfg_x0), .i_cfg_y0(i_cfg_y0), .i_cfg_w(i_cfg_w), .i_cfg_h(i_cfg_h),
    .i_cfg_skip(i_cfg_skip), .o_roi_valid(o_roi_valid), .o_roi_sof(o_roi_sof),
    .o_roi_eol(o_roi_eol), .o_roi_data(o_roi_data), .o_roi_x(o_roi_x), .o_roi_y(o_roi_y),
    .o_frame_done(o_frame_done), .o_busy(o_busy), .o_state(o_state),
    .o_cnt_captured(o_cnt_captured), .o_cnt_dropped(o_cnt_dropped)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level model: armed-and-waiting flag, frames left to skip, statistics, latched ROI.
  bit          m_wait;
  int          m_skip_rem, m_cap, m_drop;
  int          lx0, ly0, lw, lh, lskip;
  logic [7:0]  e_data;
  logic [15:0] e_x, e_y;
  int          hits, fdones;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ov(input int a0, input int len, input int lim);
    int lo, hi;
    lo = (a0 > 0) ? a0 : 0;
    hi = (a0 + len < lim) ? a0 + len : lim;
    return (hi > lo) ? hi - lo : 0;
  endfunction

  // Drive one cycle at a negedge, then check the registered response one edge later.
  task automatic step(input logic vs, input logic hs, input logic [7:0] d, input bit cap,
                      input int x, input int y, input bit fd);
    bit h;
    i_dvp_vs = vs; i_dvp_hs = hs; i_dvp_data = d;
    @(negedge i_clk);
    h = cap && vs && hs && x >= lx0 && x < lx0 + lw && y >= ly0 && y < ly0 + lh;
    if (o_roi_valid) hits++;
    if (o_frame_done) fdones++;
    chk("roi_valid", o_roi_valid, h);
    chk("frame_done", o_frame_done, fd);
    if (h) begin
      chk("roi_sof", o_roi_sof, (x == lx0 && y == ly0));
      chk("roi_eol", o_roi_eol, (x == lx0 + lw - 1));
      e_data = d; e_x = x[15:0]; e_y = y[15:0];
    end
    chk("roi_data", o_roi_data, e_data);
    chk("roi_x", o_roi_x, e_x);
    chk("roi_y", o_roi_y, e_y);
  endtask

  task automatic set_arm(input bit a);
    if (a && !m_wait) m_skip_rem = 0;
    m_wait = a;
    i_arm = a;
  endtask

  task automatic set_cfg(input int x0, input int y0, input int w, input int h, input int sk);
    i_cfg_x0 = x0[15:0]; i_cfg_y0 = y0[15:0]; i_cfg_w = w[15:0]; i_cfg_h = h[15:0];
    i_cfg_skip = sk[3:0];
  endtask

  task automatic frame(input int w, input int h, input bit arm_mid, input int rst_row,
                       input bit scramble);
    bit cap;
    int exp_hits, hits0, fd0;
    cap = 0;
    if (m_wait) begin
      if (m_skip_rem > 0) m_skip_rem--;
      else if (i_ds_ready) cap = 1;
      else if (m_drop < 65535) m_drop++;
    end
    if (cap) begin
      lx0 = i_cfg_x0; ly0 = i_cfg_y0; lw = i_cfg_w; lh = i_cfg_h; lskip = i_cfg_skip;
    end
    exp_hits = cap ? ov(lx0, lw, w) * ov(ly0, lh, h) : 0;
    hits0 = hits; fd0 = fdones;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("busy", o_busy, cap);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < h; r++) begin
      if (r == rst_row) begin
        exp_hits = cap ? ov(lx0, lw, w) * ov(ly0, lh, r) : 0;
        cap = 0; e_data = '0; e_x = '0; e_y = '0;
        i_rst = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0);
        i_rst = 1'b0;
        chk("rst_captured", o_cnt_captured, 0);
        chk("rst_dropped", o_cnt_dropped, 0);
        chk("rst_state", o_state, 0);
        chk("rst_busy", o_busy, 0);
        m_cap = 0; m_drop = 0; m_skip_rem = 0; m_wait = i_arm;
      end
      if (arm_mid && r == 1) begin
        i_arm = 1'b1; m_wait = 1; m_skip_rem = 0;
      end
      for (int c = 0; c < w; c++) step(1, 1, 8'($urandom), cap, c, r, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      if (scramble && r == 0) begin
        set_cfg($urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9),
                $urandom_range(0, 5), $urandom_range(0, 3));
      end
    end
    step(0, 0, 0, 0, 0, 0, cap);
    step(0, 0, 0, 0, 0, 0, 0);
    if (cap) begin
      if (m_cap < 65535) m_cap++;
      m_skip_rem = lskip;
    end
    chk("frame_hits", hits - hits0, exp_hits);
    chk("frame_done_cnt", fdones - fd0, cap);
    chk("cnt_captured", o_cnt_captured, m_cap);
    chk("cnt_dropped", o_cnt_dropped, m_drop);
  endtask

  initial begin
    i_rst = 1'b1; i_dvp_vs = 0; i_dvp_hs = 0; i_dvp_data = 0; i_arm = 0; i_ds_ready = 0;
    set_cfg(0, 0, 0, 0, 0);
    m_wait = 0; m_skip_rem = 0; m_cap = 0; m_drop = 0;
    lx0 = 0; ly0 = 0; lw = 0; lh = 0; lskip = 0;
    e_data = '0; e_x = '0; e_y = '0; hits = 0; fdones = 0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("reset_state", o_state, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_valid", o_roi_valid, 0);
    chk("reset_done", o_frame_done, 0);
    chk("reset_cap", o_cnt_captured, 0);
    chk("reset_drop", o_cnt_dropped, 0);
    chk("reset_data", o_roi_data, 0);
    i_rst = 1'b0;

    // Basic 8x4 capture with a 3x2 ROI at (2,1).
    set_cfg(2, 1, 3, 2, 0);
    i_ds_ready = 1;
    set_arm(1);
    hits = 0;
    frame(8, 4, 0, -1, 0);
    chk("basic_hits", hits, 6);
    chk("basic_cap", o_cnt_captured, 1);

    // Skip two frames between captures.
    set_arm(0);
    step(0, 0, 0, 0, 0, 0, 0);
    set_cfg(1, 0, 4, 3, 2);
    set_arm(1);
    for (int f = 0; f < 6; f++) frame(8, 4, 0, -1, 0);

    // Downstream not ready: dropped, then captured.
    set_arm(0);
    step(0, 0, 0, 0, 0, 0, 0);
    set_cfg(0, 0, 8, 4, 0);
    set_arm(1);
    i_ds_ready = 0;
    frame(8, 4, 0, -1, 0);
    i_ds_ready = 1;
    frame(8, 4, 0, -1, 1);

    // Arm raised mid-frame: that frame ignored, next one captured.
    set_arm(0);
    step(0, 0, 0, 0, 0, 0, 0);
    set_cfg(1, 1, 5, 3, 0);
    frame(8, 4, 1, -1, 0);
    frame(8, 4, 0, -1, 0);

    // Reset at row 2 of a captured frame, then a normal frame.
    frame(8, 5, 0, 2, 0);
    frame(8, 4, 0, -1, 0);

    // ROI near the coordinate top must not wrap; zero width still completes the frame.
    set_cfg(16'hFFFE, 0, 4, 4, 0);
    frame(8, 4, 0, -1, 0);
    set_cfg(1, 0, 0, 4, 0);
    frame(8, 4, 0, -1, 0);

    // Randomized frames and configs.
    for (int f = 0; f < 12; f++) begin
      set_cfg($urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9),
              $urandom_range(0, 5), $urandom_range(0, 2));
      i_ds_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        set_arm(0);
        step(0, 0, 0, 0, 0, 0, 0);
      end
      set_arm(1);
      frame($urandom_range(4, 10), $urandom_range(2, 5), 0, -1, $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvp_frame_scheduler.md
DVP_FRAME_SCHEDULER -- requirements
Module: dvp_frame_scheduler

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all ports listed below.
REQ-002 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 i_rst  in  1  synchronous reset, active-high.
REQ-004 i_dvp_vs, i_dvp_hs  in  1 each  DVP syncs; frame active while vs=1; pixel valid while vs&hs.
REQ-005 i_dvp_data  in  8  pixel sampled when vs&hs.
REQ-006 i_arm  in  1  level; 1 = schedule frames, 0 = stop after the current frame.
REQ-007 i_ds_ready  in  1  downstream able to take a whole frame; sampled only at frame start.
REQ-008 i_cfg_x0, i_cfg_y0, i_cfg_w, i_cfg_h  in  16 each  ROI origin and size.
REQ-009 i_cfg_skip  in  4  frames discarded between captured frames.
REQ-010 o_roi_valid, o_roi_sof, o_roi_eol  out  1 each  ROI pixel strobe, first ROI pixel, last pixel of ROI row.
REQ-011 o_roi_data  out  8; o_roi_x, o_roi_y  out  16 each  pixel and frame coordinates.
REQ-012 o_frame_done  out  1  one-cycle pulse at end of a captured frame.
REQ-013 o_busy  out  1  high in CAPTURE; o_state  out  2  encoded FSM state.
REQ-014 o_cnt_captured, o_cnt_dropped  out  16 each  saturating frame statistics.

Function
REQ-015 Edges: prev vs/hs registered; vs_rise=vs&~vs_q, vs_fall=~vs&vs_q, hs_fall=~hs&hs_q.
REQ-016 Column x: 0 on first vs&hs cycle of a line, +1 per further vs&hs cycle, cleared when ~(vs&hs).
REQ-017 Row y: cleared on vs_rise, +1 on hs_fall; both counters 16-bit and wrap at 0xFFFF.
REQ-018 FSM states IDLE=0, WAIT_SOF=1, CAPTURE=2, SKIP=3.
REQ-019 IDLE: i_arm=1 -> WAIT_SOF and skip counter cleared to 0.
REQ-020 WAIT_SOF: i_arm=0 -> IDLE; on vs_rise, skip counter nonzero -> SKIP, decrement it.
REQ-021 WAIT_SOF on vs_rise with skip counter 0: i_ds_ready=1 -> CAPTURE and latch all i_cfg_*; else -> SKIP and o_cnt_dropped+1.
REQ-022 If i_arm and vs_rise coincide in IDLE, the block SHALL go to WAIT_SOF only; partial frames are never captured.
REQ-023 CAPTURE on vs_fall: o_frame_done pulse, o_cnt_captured+1, skip counter reloaded from latched cfg_skip, -> WAIT_SOF if i_arm else IDLE.
REQ-024 SKIP on vs_fall: -> WAIT_SOF if i_arm else IDLE.
REQ-025 i_arm deassert during CAPTURE/SKIP SHALL NOT abort the frame.
REQ-026 ROI hit: CAPTURE & vs&hs & x0<=x<x0+w & y0<=y<y0+h, bounds computed 17-bit (no overflow).
REQ-027 w=0 or h=0: frame still captured and counted, no o_roi_valid.
REQ-028 o_roi_* SHALL be registered, 1-cycle latency from pixel input; x/y/data reflect that pixel.
REQ-029 o_roi_sof with the hit at (x0,y0); o_roi_eol with hits at x=x0+w-1.
REQ-030 o_roi_data/x/y SHALL hold last value when o_roi_valid=0.
REQ-031 Statistics counters SHALL saturate at 0xFFFF.
REQ-032 cfg changes outside vs_rise in WAIT_SOF SHALL have no effect on an in-progress frame.

Reset
REQ-033 i_rst SHALL force IDLE, all outputs, counters, skip counter, latched cfg and edge registers to 0.
REQ-034 Reset mid-frame SHALL discard the frame with no o_frame_done; capture resumes at the next full frame after i_arm.

Structure
REQ-035 Shared package SHALL hold the FSM state enum and width constants (COORD_W=16, PIX_W=8, SKIP_W=4).
REQ-036 One sub-module dvp_timing_tracker SHALL implement REQ-015..017, output edges and x/y.

Verification
REQ-037 Arm, ready=1, 8x4 frame, ROI x0=2,y0=1,w=3,h=2 -> 6 valid pixels, sof at (2,1), eol at x=4, 1 frame_done, captured=1.
REQ-038 cfg_skip=2, arm held, 6 frames -> frames 1 and 4 captured, captured=2, dropped=0.
REQ-039 ready=0 at vs_rise -> SKIP, dropped=1, no roi_valid; ready=1 next frame -> captured.
REQ-040 Arm asserted mid-frame (vs=1) -> no output that frame, capture begins next vs_rise.
REQ-041 Reset asserted at row 2 of CAPTURE -> outputs 0, no frame_done; next full frame captured normally.
REQ-042 x0=0xFFFE, w=4 -> no wrap false-hits; w=0 -> frame_done with zero valid pixels.
